// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes: single-cycle ops complete on the
// accept edge, MUL runs a one-bit-per-cycle shift-add for WIDTH cycles.
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       ALUFlags
);

  localparam int unsigned SW  = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_LSR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [SW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] diff_w;
  logic [SW-1:0]    sh_amt;
  logic [WIDTH:0]   lsl_w;
  logic [WIDTH:0]   lsr_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH-1:0] mul_sum;

  function automatic logic [3:0] mk_flags(input logic v, input logic c,
                                          input logic [WIDTH-1:0] r);
    return {v, c, r[MSB], (r == '0)};
  endfunction

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ALUFlags  = flags_q;

  // Single-cycle datapath; shifts are widened by one bit so the carry-out lands
  // at a fixed position and a zero shift amount naturally yields C = 0.
  always_comb begin
    sum_w   = {1'b0, A} + {1'b0, B};
    diff_w  = A - B;
    sh_amt  = B[SW-1:0];
    lsl_w   = {1'b0, A} << sh_amt;
    lsr_w   = {A, 1'b0} >> sh_amt;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (opcode)
      OP_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (A[MSB] == B[MSB]) && (sum_w[MSB] != A[MSB]);
      end
      OP_SUB: begin
        alu_res = diff_w;
        alu_c   = (A >= B);
        alu_v   = (A[MSB] != B[MSB]) && (diff_w[MSB] != A[MSB]);
      end
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_LSL: begin
        alu_res = lsl_w[WIDTH-1:0];
        alu_c   = lsl_w[WIDTH];
      end
      OP_LSR: begin
        alu_res = lsr_w[WIDTH:1];
        alu_c   = lsr_w[0];
      end
      OP_MUL: alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  assign mul_sum = prod_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state and register updates; accept is only possible in IDLE or DONE.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;

    if (accept) begin
      if (opcode == OP_MUL) begin
        state_d  = BUSY;
        mcand_d  = A;
        mplier_d = B;
        prod_d   = '0;
        cnt_d    = '0;
      end else begin
        state_d  = DONE;
        result_d = alu_res;
        flags_d  = mk_flags(alu_v, alu_c, alu_res);
      end
    end else if (state_q == BUSY) begin
      prod_d   = mul_sum;
      mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      cnt_d    = cnt_q + SW'(1);
      if (cnt_q == SW'(WIDTH - 1)) begin
        state_d  = DONE;
        cnt_d    = '0;
        result_d = mul_sum;
        flags_d  = mk_flags(1'b0, 1'b0, mul_sum);
      end
    end else if ((state_q == DONE) && out_ready) begin
      state_d = IDLE;
    end

    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= 4'b0000;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32.
module tb_alu_seq;

  localparam int unsigned W = 32;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_LSR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   ALUFlags;

  int checks   = 0;
  int failures = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .opcode   (opcode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .ALUFlags (ALUFlags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, confirm latency/busy behaviour, check result, then drain it.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_r,
                       input logic [3:0] exp_f, input int lat);
    in_valid = 1'b1;
    opcode   = op;
    A        = a;
    B        = b;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    A        = $urandom;
    B        = $urandom;
    opcode   = 3'($urandom);
    for (int k = 1; k < lat; k++) begin
      check({tag, "_busy_valid"}, 64'(out_valid), 64'(0));
      check({tag, "_busy_ready"}, 64'(in_ready), 64'(0));
      tick();
    end
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_result"}, 64'(result), 64'(exp_r));
    check({tag, "_flags"}, 64'(ALUFlags), 64'(exp_f));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    check({tag, "_drained"}, 64'(out_valid), 64'(0));
    check({tag, "_idle_ready"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    int pulses;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    opcode    = OP_ADD;
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_flags", 64'(ALUFlags), 64'(0));
    check("rst_ready", 64'(in_ready), 64'(1));

    do_op("add_ovf",  OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1010, 1);
    do_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0101, 1);
    do_op("sub_eq",   OP_SUB, 32'd5,         32'd5,         32'h0000_0000, 4'b0101, 1);
    do_op("sub_neg",  OP_SUB, 32'd3,         32'd5,         32'hFFFF_FFFE, 4'b0010, 1);
    do_op("sub_ovf",  OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b1100, 1);
    do_op("and",      OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000, 1);
    do_op("or_zero",  OP_OR,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0001, 1);
    do_op("xor",      OP_XOR, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 4'b0010, 1);
    do_op("lsl_1",    OP_LSL, 32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 4'b0100, 1);
    do_op("lsl_0",    OP_LSL, 32'h8000_0001, 32'h0000_0020, 32'h8000_0001, 4'b0010, 1);
    do_op("lsr_1",    OP_LSR, 32'h8000_0001, 32'h0000_0001, 32'h4000_0000, 4'b0100, 1);
    do_op("lsr_hi",   OP_LSR, 32'h0000_0001, 32'h0000_0021, 32'h0000_0000, 4'b0101, 1);
    do_op("mul_zero", OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b0001, 33);
    do_op("mul_7x6",  OP_MUL, 32'd7,         32'd6,         32'd42,        4'b0000, 33);
    do_op("mul_ff",   OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, 33);

    // Backpressure: held result must stay put and a pending request must not slip in.
    in_valid = 1'b1;
    opcode   = OP_ADD;
    A        = 32'd1;
    B        = 32'd2;
    tick();
    opcode = OP_AND;
    A      = 32'h0000_FF00;
    B      = 32'h0000_0F0F;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 64'(out_valid), 64'(1));
      check("bp_result", 64'(result), 64'(3));
      check("bp_flags", 64'(ALUFlags), 64'(0));
      check("bp_ready", 64'(in_ready), 64'(0));
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("b2b_ready", 64'(in_ready), 64'(1));
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_valid", 64'(out_valid), 64'(1));
    check("b2b_result", 64'(result), 64'(32'h0000_0F00));
    check("b2b_flags", 64'(ALUFlags), 64'(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("b2b_drained", 64'(out_valid), 64'(0));

    // Leave non-zero result/flags registered before the mid-MUL reset.
    do_op("pre_rst", OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b0010, 1);
    in_valid = 1'b1;
    opcode   = OP_MUL;
    A        = 32'd7;
    B        = 32'd6;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    check("mid_busy", 64'(in_ready), 64'(0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_valid", 64'(out_valid), 64'(0));
    check("mrst_result", 64'(result), 64'(0));
    check("mrst_flags", 64'(ALUFlags), 64'(0));
    check("mrst_ready", 64'(in_ready), 64'(1));
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) pulses++;
      tick();
    end
    check("mrst_no_stale", 64'(pulses), 64'(0));

    // Reset wins over a simultaneous accept.
    in_valid = 1'b1;
    opcode   = OP_ADD;
    A        = 32'd9;
    B        = 32'd9;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    check("rst_acc_valid", 64'(out_valid), 64'(0));
    tick();
    check("rst_acc_later", 64'(out_valid), 64'(0));
    check("rst_acc_result", 64'(result), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
